// File: rtl/char_cell_tracker_pkg.sv
// Shared geometry for the character-cell tracker: zoom codes, tracking states,
// and elaboration-time helpers for grid sizes and field widths.
package char_grid_pkg;

    localparam logic [1:0] ZOOM_1X = 2'b00;
    localparam logic [1:0] ZOOM_2X = 2'b01;
    localparam logic [1:0] ZOOM_4X = 2'b10;

    typedef enum logic {
        UNSYNC = 1'b0,
        TRACK  = 1'b1
    } track_state_e;

    function automatic int grid_cells(input int screen, input int font, input int z);
        return screen / (font * z);
    endfunction

    function automatic int ci_width(input int sw, input int sh, input int fw, input int fh);
        return $clog2((sw / fw) * (sh / fh));
    endfunction

    function automatic int glyph_width(input int font);
        return (font > 1) ? $clog2(font) : 1;
    endfunction

    // Grid sizes for the default 640x480 screen with a 10x12 font
    localparam int NCW_1 = grid_cells(640, 10, 1);
    localparam int NCW_2 = grid_cells(640, 10, 2);
    localparam int NCW_4 = grid_cells(640, 10, 4);
    localparam int NCH_1 = grid_cells(480, 12, 1);
    localparam int NCH_2 = grid_cells(480, 12, 2);
    localparam int NCH_4 = grid_cells(480, 12, 4);

endpackage

// File: rtl/char_cell_tracker_axis_cell_counter.sv
// One raster axis: zoom sub-count -> glyph count -> cell count, saturating at the
// grid edge. Outputs show the post-update position so the parent can register it.
module axis_cell_counter
    import char_grid_pkg::*;
#(
    parameter int FONT = 10,
    parameter int NC1  = 64,
    parameter int NC2  = 32,
    parameter int NC4  = 16,
    localparam int GW  = glyph_width(FONT),
    localparam int CW  = $clog2(NC1 + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step_i,
    input  logic          clear_i,
    input  logic [1:0]    zoom_i,
    output logic [1:0]    sub_o,
    output logic [GW-1:0] glyph_o,
    output logic [CW-1:0] cell_o,
    output logic          sat_o,
    output logic          cell_inc_o
);

    logic [1:0]    sub_q, sub_d, sub_max;
    logic [GW-1:0] glyph_q, glyph_d;
    logic [CW-1:0] cell_q, cell_d, cell_lim;

    always_comb begin
        case (zoom_i)
            ZOOM_2X: begin sub_max = 2'd1; cell_lim = CW'(NC2); end
            ZOOM_4X: begin sub_max = 2'd3; cell_lim = CW'(NC4); end
            default: begin sub_max = 2'd0; cell_lim = CW'(NC1); end
        endcase
    end

    always_comb begin
        sub_d      = sub_q;
        glyph_d    = glyph_q;
        cell_d     = cell_q;
        cell_inc_o = 1'b0;
        if (clear_i) begin
            sub_d   = '0;
            glyph_d = '0;
            cell_d  = '0;
        end else if (step_i && (cell_q != cell_lim)) begin
            if (sub_q >= sub_max) begin
                sub_d = '0;
                if (glyph_q == GW'(FONT - 1)) begin
                    glyph_d    = '0;
                    cell_d     = cell_q + 1'b1;
                    cell_inc_o = 1'b1;
                end else begin
                    glyph_d = glyph_q + 1'b1;
                end
            end else begin
                sub_d = sub_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sub_q   <= '0;
            glyph_q <= '0;
            cell_q  <= '0;
        end else begin
            sub_q   <= sub_d;
            glyph_q <= glyph_d;
            cell_q  <= cell_d;
        end
    end

    assign sub_o   = sub_d;
    assign glyph_o = glyph_d;
    assign cell_o  = cell_d;
    assign sat_o   = (cell_d == cell_lim);

endmodule

// File: rtl/char_cell_tracker.sv
// Raster-to-character-cell mapper with per-frame zoom (1x/2x/4x), 1-cycle latency.
// Define CHAR_CURSOR_EN to add the blinking cursor-hit output.
module char_cell_tracker
    import char_grid_pkg::*;
#(
    parameter int FONT_W   = 10,
    parameter int FONT_H   = 12,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    localparam int CIW = ci_width(SCREEN_W, SCREEN_H, FONT_W, FONT_H),
    localparam int GXW = glyph_width(FONT_W),
    localparam int GYW = glyph_width(FONT_H)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           px_valid,
    input  logic           sof,
    input  logic           sol,
    input  logic [1:0]     zoom,
`ifdef CHAR_CURSOR_EN
    input  logic [CIW-1:0] cursor_ci,
    input  logic           cursor_en,
    output logic           cursor_hit,
`endif
    output logic [CIW-1:0] ci,
    output logic [GXW-1:0] gx,
    output logic [GYW-1:0] gy,
    output logic           off_limits,
    output logic           out_valid
);

    localparam int NCW1 = grid_cells(SCREEN_W, FONT_W, 1);
    localparam int NCW2 = grid_cells(SCREEN_W, FONT_W, 2);
    localparam int NCW4 = grid_cells(SCREEN_W, FONT_W, 4);
    localparam int NCH1 = grid_cells(SCREEN_H, FONT_H, 1);
    localparam int NCH2 = grid_cells(SCREEN_H, FONT_H, 2);
    localparam int NCH4 = grid_cells(SCREEN_H, FONT_H, 4);
    localparam int XCW  = $clog2(NCW1 + 1);
    localparam int YCW  = $clog2(NCH1 + 1);

    track_state_e   state_q, state_d;
    logic [1:0]     zoom_q, zoom_d;
    logic           acc_sof, x_clear, x_step, y_step;
    logic [CIW-1:0] row_base_q, row_base_d, ncw_eff;
    logic [CIW-1:0] ci_q, ci_d;
    logic [GXW-1:0] gx_q, gx_d;
    logic [GYW-1:0] gy_q, gy_d;
    logic           off_q, off_d, vld_q;

    logic [1:0]     x_sub, y_sub;
    logic [GXW-1:0] x_glyph;
    logic [GYW-1:0] y_glyph;
    logic [XCW-1:0] x_cell;
    logic [YCW-1:0] y_cell;
    logic           x_sat, y_sat, x_inc, y_inc;
    logic           unused_counts;

    assign acc_sof = px_valid & sof;
    assign x_clear = px_valid & (sof | sol);
    assign x_step  = px_valid & ~sof & ~sol;
    assign y_step  = px_valid & sol & ~sof;

    // The sof pixel already uses the zoom it latches
    always_comb begin
        zoom_d = zoom_q;
        if (acc_sof)
            zoom_d = ((zoom == ZOOM_2X) || (zoom == ZOOM_4X)) ? zoom : ZOOM_1X;
    end

    always_comb begin
        case (zoom_d)
            ZOOM_2X: ncw_eff = CIW'(NCW2);
            ZOOM_4X: ncw_eff = CIW'(NCW4);
            default: ncw_eff = CIW'(NCW1);
        endcase
    end

    axis_cell_counter #(.FONT(FONT_W), .NC1(NCW1), .NC2(NCW2), .NC4(NCW4)) u_x (
        .clk(clk), .rst(rst), .step_i(x_step), .clear_i(x_clear), .zoom_i(zoom_d),
        .sub_o(x_sub), .glyph_o(x_glyph), .cell_o(x_cell), .sat_o(x_sat), .cell_inc_o(x_inc)
    );

    axis_cell_counter #(.FONT(FONT_H), .NC1(NCH1), .NC2(NCH2), .NC4(NCH4)) u_y (
        .clk(clk), .rst(rst), .step_i(y_step), .clear_i(acc_sof), .zoom_i(zoom_d),
        .sub_o(y_sub), .glyph_o(y_glyph), .cell_o(y_cell), .sat_o(y_sat), .cell_inc_o(y_inc)
    );

    assign unused_counts = ^{x_sub, y_sub, x_inc};

    always_comb begin
        row_base_d = row_base_q;
        if (acc_sof)
            row_base_d = '0;
        else if (y_inc && !y_sat)
            row_base_d = row_base_q + ncw_eff;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= UNSYNC;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == UNSYNC && acc_sof)
            state_d = TRACK;
    end

    always_comb begin
        off_d = (state_d == UNSYNC) | x_sat | y_sat;
        ci_d  = '0;
        gx_d  = '0;
        gy_d  = '0;
        if (!off_d) begin
            ci_d = row_base_d + CIW'(x_cell);
            gx_d = x_glyph;
            gy_d = y_glyph;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q      <= 1'b0;
            off_q      <= 1'b0;
            ci_q       <= '0;
            gx_q       <= '0;
            gy_q       <= '0;
            zoom_q     <= ZOOM_1X;
            row_base_q <= '0;
        end else begin
            vld_q      <= px_valid;
            zoom_q     <= zoom_d;
            row_base_q <= row_base_d;
            if (px_valid) begin
                off_q <= off_d;
                ci_q  <= ci_d;
                gx_q  <= gx_d;
                gy_q  <= gy_d;
            end
        end
    end

    assign ci         = ci_q;
    assign gx         = gx_q;
    assign gy         = gy_q;
    assign off_limits = off_q;
    assign out_valid  = vld_q;

`ifdef CHAR_CURSOR_EN
    logic [4:0] frame_q;
    logic       blink_q, hit_q, hit_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q <= '0;
            blink_q <= 1'b1;
        end else if (acc_sof) begin
            frame_q <= frame_q + 5'd1;
            if (frame_q == '1)
                blink_q <= ~blink_q;
        end
    end

    assign hit_d = cursor_en & blink_q & ~off_d & (ci_d == cursor_ci) & (gy_d == GYW'(FONT_H - 1));

    always_ff @(posedge clk) begin
        if (rst)           hit_q <= 1'b0;
        else if (px_valid) hit_q <= hit_d;
    end

    assign cursor_hit = hit_q;
`endif

endmodule

// File: tb/tb_char_cell_tracker.sv
// Directed bench for char_cell_tracker: a 640x480 and a 645x485 instance share
// stimulus and are checked each cycle against a divide-based position model.
module tb_char_cell_tracker;

    localparam int FW = 10;
    localparam int FH = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       px_valid = 1'b0;
    logic       sof = 1'b0;
    logic       sol = 1'b0;
    logic [1:0] zoom = 2'b00;

    logic [11:0] ci_a, ci_b;
    logic [3:0]  gx_a, gx_b, gy_a, gy_b;
    logic        off_a, off_b, ov_a, ov_b;
`ifdef CHAR_CURSOR_EN
    logic [11:0] cursor_ci = 12'd65;
    logic        cursor_en = 1'b1;
    logic        hit_a, hit_b;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    char_cell_tracker dut_a (
        .clk(clk), .rst(rst), .px_valid(px_valid), .sof(sof), .sol(sol), .zoom(zoom),
`ifdef CHAR_CURSOR_EN
        .cursor_ci(cursor_ci), .cursor_en(cursor_en), .cursor_hit(hit_a),
`endif
        .ci(ci_a), .gx(gx_a), .gy(gy_a), .off_limits(off_a), .out_valid(ov_a)
    );

    char_cell_tracker #(.SCREEN_W(645), .SCREEN_H(485)) dut_b (
        .clk(clk), .rst(rst), .px_valid(px_valid), .sof(sof), .sol(sol), .zoom(zoom),
`ifdef CHAR_CURSOR_EN
        .cursor_ci(cursor_ci), .cursor_en(cursor_en), .cursor_hit(hit_b),
`endif
        .ci(ci_b), .gx(gx_b), .gy(gy_b), .off_limits(off_b), .out_valid(ov_b)
    );

    // Model: absolute pixel/line position of the last accepted pixel
    bit mseen = 0, msync = 0, mvld = 0;
    int mz = 1, mx = 0, my = 0, msofs = 0;

    function automatic int zdec(input logic [1:0] z);
        return (z == 2'b01) ? 2 : (z == 2'b10) ? 4 : 1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mseen <= 0; msync <= 0; mvld <= 0;
            mz <= 1; mx <= 0; my <= 0; msofs <= 0;
        end else begin
            mvld <= px_valid;
            if (px_valid) begin
                mseen <= 1;
                msync <= msync | sof;
                if (sof) begin
                    mz    <= zdec(zoom);
                    msofs <= msofs + 1;
                end
                mx <= (sof || sol) ? 0 : mx + 1;
                my <= sof ? 0 : (sol ? my + 1 : my);
            end
        end
    end

    // {off_limits, ci[11:0], gx[3:0], gy[3:0]}
    function automatic logic [20:0] expect_out(input int sw, input int sh, input bit seen,
                                               input bit sync, input int z, input int x, input int y);
        int ncw, nch, cx, cy;
        ncw = sw / (FW * z);
        nch = sh / (FH * z);
        cx  = x / (FW * z);
        cy  = y / (FH * z);
        if (!seen) return '0;
        if (!sync || cx >= ncw || cy >= nch) return {1'b1, 20'd0};
        return {1'b0, 12'(cy * ncw + cx), 4'((x / z) % FW), 4'((y / z) % FH)};
    endfunction

    task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model640", {ov_a, off_a, ci_a, gx_a, gy_a},
              {mvld, expect_out(640, 480, mseen, msync, mz, mx, my)});
        check("model645", {ov_b, off_b, ci_b, gx_b, gy_b},
              {mvld, expect_out(645, 485, mseen, msync, mz, mx, my)});
`ifdef CHAR_CURSOR_EN
        begin
            logic [20:0] e;
            logic        eh;
            e  = expect_out(640, 480, mseen, msync, mz, mx, my);
            eh = mseen && msync && !e[20] && (e[19:8] == cursor_ci) && (e[3:0] == 4'(FH - 1))
                 && cursor_en && ((msofs / 32) % 2 == 0);
            check("hit_model", 22'(hit_a), 22'(eh));
        end
`endif
    end

    task automatic cyc(input logic v, input logic f, input logic l);
        px_valid = v; sof = f; sol = l;
        @(posedge clk);
        #1;
        px_valid = 1'b0; sof = 1'b0; sol = 1'b0;
    endtask

    task automatic start_line(input logic f);
        cyc(1'b1, f, 1'b1);
    endtask

    task automatic more(input int k);
        repeat (k) cyc(1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle(input int k);
        repeat (k) cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic pin(input string name, input logic off, input logic [11:0] eci,
                       input logic [3:0] egx, input logic [3:0] egy);
        check(name, {ov_a, off_a, ci_a, gx_a, gy_a}, {1'b1, off, eci, egx, egy});
    endtask

`ifdef CHAR_CURSOR_EN
    task automatic cursor_frame(input string name, input logic exp_hit);
        start_line(1'b1);
        more(25);
        for (int l = 1; l < 25; l++) begin
            start_line(1'b0);
            if (l == 23) begin
                more(12);
                check(name, 22'(hit_a), 22'(exp_hit));
                more(13);
            end else begin
                more(25);
            end
        end
    endtask
`endif

    initial begin
        idle(2);
        check("reset_state", {ov_a, off_a, ci_a, gx_a, gy_a}, 22'd0);
        cyc(1'b1, 1'b1, 1'b1);
        check("reset_pixel", {ov_a, off_a, ci_a, gx_a, gy_a}, 22'd0);
        rst = 1'b0;

        more(3);
        pin("unsync_px", 1'b1, 12'd0, 4'd0, 4'd0);

        zoom = 2'b00;
        start_line(1'b1);
        pin("z1_px0", 1'b0, 12'd0, 4'd0, 4'd0);
        more(9);
        pin("z1_px9", 1'b0, 12'd0, 4'd9, 4'd0);
        more(1);
        pin("z1_px10", 1'b0, 12'd1, 4'd0, 4'd0);
        more(629);
        pin("z1_px639", 1'b0, 12'd63, 4'd9, 4'd0);
        more(1);
        pin("z1_px640", 1'b1, 12'd0, 4'd0, 4'd0);
        idle(3);
        check("gap_hold", {ov_a, off_a, ci_a, gx_a, gy_a}, {1'b0, 1'b1, 20'd0});
        for (int l = 1; l < 12; l++) start_line(1'b0);
        start_line(1'b0);
        pin("z1_line12", 1'b0, 12'd64, 4'd0, 4'd0);
        for (int l = 13; l < 480; l++) start_line(1'b0);
        more(639);
        pin("z1_last", 1'b0, 12'd2559, 4'd9, 4'd11);
        more(5);
        pin("z1_px644", 1'b1, 12'd0, 4'd0, 4'd0);
        for (int l = 480; l < 485; l++) begin
            start_line(1'b0);
            more(2);
        end
        pin("z1_line484", 1'b1, 12'd0, 4'd0, 4'd0);

        zoom = 2'b01;
        start_line(1'b1);
        more(19);
        pin("z2_px19", 1'b0, 12'd0, 4'd9, 4'd0);
        more(1);
        pin("z2_px20", 1'b0, 12'd1, 4'd0, 4'd0);
        zoom = 2'b10;
        for (int l = 1; l < 480; l++) start_line(1'b0);
        more(639);
        pin("z2_last", 1'b0, 12'd639, 4'd9, 4'd11);

        start_line(1'b1);
        more(40);
        pin("z4_px40", 1'b0, 12'd1, 4'd0, 4'd0);

        zoom = 2'b11;
        start_line(1'b1);
        more(10);
        pin("z3_px10", 1'b0, 12'd1, 4'd0, 4'd0);

        more(5);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        more(2);
        pin("rst_unsync", 1'b1, 12'd0, 4'd0, 4'd0);
        zoom = 2'b00;
        start_line(1'b1);
        pin("resync_px0", 1'b0, 12'd0, 4'd0, 4'd0);
        more(5);
        idle(4);
        more(5);
        pin("gap_px10", 1'b0, 12'd1, 4'd0, 4'd0);

`ifdef CHAR_CURSOR_EN
        cursor_frame("hit_on", 1'b1);
        repeat (30) start_line(1'b1);
        cursor_frame("hit_blink_off", 1'b0);
`endif

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
